// File: rtl/net_link_controller.sv
// net_link_controller: serial link between the processor's network
// send/receive instructions and the Arduino. The transmitter sends
// {data, dest} as one UART-style frame; the receiver deserialises 32-bit
// words into a single-entry holding register.
module net_link_controller #(
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned DEST_W  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flagSend,
    input  logic        flagReceive,
    input  logic [31:0] netDest,
    input  logic [31:0] netData,
    input  logic        rxLine,
    output logic        txLine,
    output logic [31:0] netDataArduino,
    output logic        txBusy,
    output logic        rxValid,
    output logic        rxOverrun,
    output logic        rxFrameErr,
    output logic        txDrop
);

    localparam int unsigned TX_W = DEST_W + 32;
    localparam int unsigned PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TB_W = $clog2(TX_W);

    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_MID   = PH_W'(CLK_DIV / 2);
    localparam logic [TB_W-1:0] TXB_LAST = TB_W'(TX_W - 1);
    localparam logic [4:0]      RXB_LAST = 5'd31;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Only the low DEST_W bits of the destination go on the wire.
    if (DEST_W < 32) begin : g_dest_unused
        logic unused_dest_hi;
        assign unused_dest_hi = ^netDest[31:DEST_W];
    end

    // ---------------- transmitter ----------------
    logic [1:0]      tx_state_q, tx_state_d;
    logic [PH_W-1:0] tx_phase_q, tx_phase_d;
    logic [TB_W-1:0] tx_bit_q,   tx_bit_d;
    logic [TX_W-1:0] tx_shift_q, tx_shift_d;
    logic            tx_line_q,  tx_line_d;
    logic            tx_busy_q,  tx_busy_d;
    logic            tx_drop_q,  tx_drop_d;

    // TX next state: frame sequencing, bit timing and drop detection
    always_comb begin
        tx_state_d = tx_state_q;
        tx_phase_d = tx_phase_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_busy_d  = tx_busy_q;
        tx_drop_d  = flagSend && (tx_state_q != S_IDLE);
        case (tx_state_q)
            S_IDLE: begin
                if (flagSend) begin
                    tx_shift_d = {netData, netDest[DEST_W-1:0]};
                    tx_state_d = S_START;
                    tx_phase_d = '0;
                    tx_line_d  = 1'b0;
                    tx_busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (tx_phase_q == PH_LAST) begin
                    tx_state_d = S_DATA;
                    tx_phase_d = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                end else begin
                    tx_phase_d = tx_phase_q + PH_W'(1);
                end
            end
            S_DATA: begin
                if (tx_phase_q == PH_LAST) begin
                    tx_phase_d = '0;
                    if (tx_bit_q == TXB_LAST) begin
                        tx_state_d = S_STOP;
                        tx_line_d  = 1'b1;
                    end else begin
                        // bit 0 of the shifter is the bit on the line
                        tx_bit_d   = tx_bit_q + TB_W'(1);
                        tx_shift_d = tx_shift_q >> 1;
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_phase_d = tx_phase_q + PH_W'(1);
                end
            end
            S_STOP: begin
                if (tx_phase_q == PH_LAST) begin
                    tx_state_d = S_IDLE;
                    tx_phase_d = '0;
                    tx_busy_d  = 1'b0;
                end else begin
                    tx_phase_d = tx_phase_q + PH_W'(1);
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // TX registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_phase_q <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_drop_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_phase_q <= tx_phase_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            tx_busy_q  <= tx_busy_d;
            tx_drop_q  <= tx_drop_d;
        end
    end

    // ---------------- receiver ----------------
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]      rx_state_q, rx_state_d;
    logic [PH_W-1:0] rx_phase_q, rx_phase_d;
    logic [4:0]      rx_bit_q,   rx_bit_d;
    logic [31:0]     rx_shift_q, rx_shift_d;
    logic [31:0]     rx_data_q,  rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_ovr_q,   rx_ovr_d;
    logic            rx_ferr_q,  rx_ferr_d;

    // RX next state: start detection, mid-bit sampling, commit and read-out
    always_comb begin
        rx_state_d = rx_state_q;
        rx_phase_d = rx_phase_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q && !flagReceive;
        rx_ovr_d   = rx_ovr_q;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = S_START;
                    rx_phase_d = '0;
                end
            end
            S_START: begin
                if (rx_phase_q == PH_MID) begin
                    rx_phase_d = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    rx_phase_d = rx_phase_q + PH_W'(1);
                end
            end
            S_DATA: begin
                if (rx_phase_q == PH_LAST) begin
                    rx_phase_d = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[31:1]};
                    rx_bit_d   = rx_bit_q + 5'd1;
                    if (rx_bit_q == RXB_LAST) begin
                        rx_state_d = S_STOP;
                    end
                end else begin
                    rx_phase_d = rx_phase_q + PH_W'(1);
                end
            end
            S_STOP: begin
                if (rx_phase_q == PH_LAST) begin
                    rx_state_d = S_IDLE;
                    rx_phase_d = '0;
                    if (rx_sync_q) begin
                        // a read in the same cycle consumes the old word, so no overrun
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        if (rx_valid_q && !flagReceive) begin
                            rx_ovr_d = 1'b1;
                        end
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end else begin
                    rx_phase_d = rx_phase_q + PH_W'(1);
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // RX registers, including the two-flop input synchroniser
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_phase_q <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rxLine;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_phase_q <= rx_phase_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign txLine         = tx_line_q;
    assign txBusy         = tx_busy_q;
    assign txDrop         = tx_drop_q;
    assign netDataArduino = rx_data_q;
    assign rxValid        = rx_valid_q;
    assign rxOverrun      = rx_ovr_q;
    assign rxFrameErr     = rx_ferr_q;

endmodule

// File: tb/tb_net_link_controller.sv
// Bench for net_link_controller: directed sequence with random payloads,
// checked against a frame-level model of the serial link.
module tb_net_link_controller;

    localparam int CLK_DIV = 4;
    localparam int DEST_W  = 8;
    localparam int N_TX    = DEST_W + 34;

    logic        clock = 1'b0;
    logic        reset;
    logic        flagSend;
    logic        flagReceive;
    logic [31:0] netDest;
    logic [31:0] netData;
    logic        rxLine;
    logic        txLine;
    logic [31:0] netDataArduino;
    logic        txBusy;
    logic        rxValid;
    logic        rxOverrun;
    logic        rxFrameErr;
    logic        txDrop;

    always #5 clock = ~clock;

    net_link_controller #(.CLK_DIV(CLK_DIV), .DEST_W(DEST_W)) dut (
        .clock(clock), .reset(reset), .flagSend(flagSend), .flagReceive(flagReceive),
        .netDest(netDest), .netData(netData), .rxLine(rxLine), .txLine(txLine),
        .netDataArduino(netDataArduino), .txBusy(txBusy), .rxValid(rxValid),
        .rxOverrun(rxOverrun), .rxFrameErr(rxFrameErr), .txDrop(txDrop)
    );

    int tests = 0;
    int fails = 0;
    int fe_cnt = 0;
    int drop_cnt = 0;
    bit rx_q[$];

    // receiver model: holding register contents as seen by software
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc_begin();
        @(posedge clock);
        #1;
        rxLine = (rx_q.size() > 0) ? rx_q.pop_front() : 1'b1;
    endtask

    task automatic cyc_end();
        @(negedge clock);
        fe_cnt   += int'(rxFrameErr);
        drop_cnt += int'(txDrop);
    endtask

    task automatic tick();
        cyc_begin();
        cyc_end();
    endtask

    task automatic push_frame(input logic [31:0] d, input bit stop_bit);
        repeat (CLK_DIV) rx_q.push_back(1'b0);
        for (int i = 0; i < 32; i++) repeat (CLK_DIV) rx_q.push_back(d[i]);
        repeat (CLK_DIV) rx_q.push_back(stop_bit);
    endtask

    task automatic rx_run();
        for (int n = 0; n < 400 && rx_q.size() > 0; n++) tick();
        repeat (4) tick();
    endtask

    task automatic rx_model_good(input logic [31:0] d);
        if (m_valid) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_data  = d;
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_data"},  netDataArduino, m_data);
        chk({tag, "_valid"}, rxValid, m_valid);
        chk({tag, "_ovr"},   rxOverrun, m_ovr);
    endtask

    // expected line level during wire bit b of a frame
    function automatic logic tx_bit_exp(input logic [31:0] dest, input logic [31:0] data, input int b);
        if (b == 0)            return 1'b0;
        if (b <= DEST_W)       return dest[b-1];
        if (b <= DEST_W + 32)  return data[b-1-DEST_W];
        return 1'b1;
    endfunction

    // Caller has already presented flagSend for one cycle; checks the whole
    // busy window plus the first idle cycle, optionally issuing the next request there.
    task automatic tx_frame(input logic [31:0] dest, input logic [31:0] data, input int drop_at,
                            input bit b2b, input logic [31:0] nd, input logic [31:0] ndata);
        for (int k = 0; k < N_TX * CLK_DIV; k++) begin
            cyc_begin();
            flagSend = (k == drop_at);
            if (k == drop_at) begin
                netDest = $urandom;
                netData = $urandom;
            end
            cyc_end();
            chk("tx_line", txLine, tx_bit_exp(dest, data, k / CLK_DIV));
            chk("tx_busy", txBusy, 1);
            chk("tx_drop", txDrop, (drop_at >= 0 && k == drop_at + 1));
        end
        cyc_begin();
        flagSend = b2b;
        if (b2b) begin
            netDest = nd;
            netData = ndata;
        end
        cyc_end();
        chk("tx_busy_end", txBusy, 0);
        chk("tx_line_end", txLine, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d1, d2, nd, ndat;
        reset = 1'b1; flagSend = 1'b0; flagReceive = 1'b0;
        netDest = '0; netData = '0; rxLine = 1'b1;
        m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_txline", txLine, 1);
        chk("rst_txbusy", txBusy, 0);
        chk("rst_data", netDataArduino, 0);
        chk("rst_valid", rxValid, 0);
        chk("rst_ovr", rxOverrun, 0);
        chk("rst_ferr", rxFrameErr, 0);
        chk("rst_drop", txDrop, 0);
        cyc_begin(); reset = 1'b0; cyc_end();

        // TX: A5/DEADBEEF with a dropped request, then a back-to-back frame
        nd = $urandom; ndat = $urandom;
        drop_cnt = 0;
        cyc_begin(); flagSend = 1'b1; netDest = 32'h0000_00A5; netData = 32'hDEAD_BEEF; cyc_end();
        tx_frame(32'h0000_00A5, 32'hDEAD_BEEF, 9, 1'b1, nd, ndat);
        tx_frame(nd, ndat, -10, 1'b0, '0, '0);
        chk("tx_drop_count", drop_cnt, 1);

        // RX: single good frame, then read it
        fe_cnt = 0;
        push_frame(32'h1234_5678, 1'b1);
        rx_run();
        rx_model_good(32'h1234_5678);
        check_rx("rx_first");
        cyc_begin(); flagReceive = 1'b1; cyc_end();
        cyc_begin(); flagReceive = 1'b0; cyc_end();
        m_valid = 1'b0;
        check_rx("rx_read");

        // RX: read issued in the same cycle as the next commit
        d1 = $urandom; d2 = $urandom;
        push_frame(d1, 1'b1);
        rx_run();
        rx_model_good(d1);
        check_rx("rx_unread");
        push_frame(d2, 1'b1);
        for (int t = 0; t < 150; t++) begin
            cyc_begin();
            flagReceive = (t == 137);
            cyc_end();
        end
        repeat (4) tick();
        m_data = d2;
        check_rx("rx_collide");
        cyc_begin(); flagReceive = 1'b1; cyc_end();
        cyc_begin(); flagReceive = 1'b0; cyc_end();
        m_valid = 1'b0;
        check_rx("rx_read2");

        // read with nothing pending
        cyc_begin(); flagReceive = 1'b1; cyc_end();
        cyc_begin(); flagReceive = 1'b0; cyc_end();
        check_rx("rx_read_empty");

        // two unread frames -> overrun
        push_frame(32'h0000_0001, 1'b1);
        repeat ($urandom_range(2, 8)) rx_q.push_back(1'b1);
        push_frame(32'h0000_0002, 1'b1);
        rx_run();
        rx_model_good(32'h0000_0001);
        rx_model_good(32'h0000_0002);
        check_rx("rx_overrun");

        // bad stop bit
        fe_cnt = 0;
        push_frame($urandom, 1'b0);
        repeat (8) rx_q.push_back(1'b1);
        rx_run();
        chk("rx_ferr_count", fe_cnt, 1);
        check_rx("rx_ferr");

        // one-cycle glitch on idle line, then a good frame
        fe_cnt = 0;
        rx_q.push_back(1'b0);
        repeat (160) tick();
        chk("rx_glitch_ferr", fe_cnt, 0);
        check_rx("rx_glitch");
        d1 = $urandom;
        push_frame(d1, 1'b1);
        rx_run();
        rx_model_good(d1);
        check_rx("rx_after_glitch");

        // reset in the middle of concurrent TX and RX frames
        push_frame($urandom, 1'b1);
        cyc_begin(); flagSend = 1'b1; netDest = $urandom; netData = $urandom; cyc_end();
        cyc_begin(); flagSend = 1'b0; cyc_end();
        repeat (80) tick();
        cyc_begin(); reset = 1'b1; cyc_end();
        cyc_begin(); reset = 1'b0; rx_q.delete(); rxLine = 1'b1; cyc_end();
        m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
        chk("mid_rst_txline", txLine, 1);
        chk("mid_rst_txbusy", txBusy, 0);
        check_rx("mid_rst");
        repeat (3) tick();

        // fresh TX and RX frames in parallel after reset
        d1 = $urandom; nd = $urandom; ndat = $urandom;
        fe_cnt = 0;
        push_frame(d1, 1'b1);
        cyc_begin(); flagSend = 1'b1; netDest = nd; netData = ndat; cyc_end();
        tx_frame(nd, ndat, -10, 1'b0, '0, '0);
        repeat (4) tick();
        rx_model_good(d1);
        check_rx("post_rst_rx");
        chk("post_rst_ferr", fe_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
